// File: rtl/multi_seq_detector.sv
// multi_seq_detector: matches up to NUM_PAT programmable serial bit patterns
// against a qualified 1-bit stream. Each pattern has a registered match pulse
// and a saturating hit counter. Matching can be overlapping or non-overlapping.
module multi_seq_detector #(
  parameter int NUM_PAT = 2,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8,
  parameter logic [NUM_PAT*PAT_LEN-1:0] DEF_PATS = {4'b1001, 4'b1011},
  parameter int DEF_LEN = PAT_LEN,
  localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  localparam int LEN_W  = $clog2(PAT_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     x_valid,
  input  logic                     x,
  input  logic                     overlap,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic [PAT_LEN-1:0]       cfg_pat,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     clr_cnt,
  output logic [NUM_PAT-1:0]       detect,
  output logic                     any_detect,
  output logic [NUM_PAT*CNT_W-1:0] hit_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Only PAT_LEN-1 past bits are ever needed: the newest bit comes straight
  // from x when forming the candidate window.
  logic [PAT_LEN-2:0] hist_reg;
  logic [PAT_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_reg;
  logic [LEN_W-1:0]   fill_next;
  logic [NUM_PAT-1:0] match;
  logic [NUM_PAT-1:0] detect_reg;
  logic               any_reg;
  logic               idx_ok;
  logic               cfg_hit;
  logic               accept;
  logic [LEN_W-1:0]   cfg_len_clamped;

  // Slot index range check; constant-true when every index value is a real slot.
  if ((1 << IDX_W) == NUM_PAT) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = (cfg_idx < IDX_W'(NUM_PAT));
  end

  // A valid config write takes priority and swallows a same-edge data bit.
  assign cfg_hit         = cfg_we && idx_ok;
  assign accept          = x_valid && !cfg_hit;
  assign hist_next       = {hist_reg, x};
  assign fill_next       = (fill_reg == LEN_MAX) ? fill_reg : fill_reg + 1'b1;
  assign cfg_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

  // Shared history shift register and fill level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (cfg_hit) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (x_valid) begin
      hist_reg <= hist_next[PAT_LEN-2:0];
      fill_reg <= fill_next;
    end
  end

  for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_pat
    logic [PAT_LEN-1:0] pat_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   since_reg;
    logic [LEN_W-1:0]   since_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               pat_eq;

    // Compare only the lowest len bits of the window against the pattern.
    always_comb begin
      pat_eq = 1'b1;
      for (int j = 0; j < PAT_LEN; j++) begin
        if ((LEN_W'(j) < len_reg) && (hist_next[j] != pat_reg[j])) begin
          pat_eq = 1'b0;
        end
      end
    end

    assign since_next = (since_reg == LEN_MAX) ? since_reg : since_reg + 1'b1;
    assign match[gi]  = accept && (len_reg != '0) && (fill_next >= len_reg) &&
                        pat_eq && (overlap || (since_next >= len_reg));

    // Per-slot pattern and length, loaded from defaults or by config write.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pat_reg <= DEF_PATS[gi*PAT_LEN +: PAT_LEN];
        len_reg <= LEN_W'(DEF_LEN);
      end else if (cfg_hit && (cfg_idx == IDX_W'(gi))) begin
        pat_reg <= cfg_pat;
        len_reg <= cfg_len_clamped;
      end
    end

    // Bits seen since the last match, used to gate non-overlapping matches.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        since_reg <= LEN_MAX;
      end else if (cfg_hit) begin
        since_reg <= LEN_MAX;
      end else if (accept) begin
        since_reg <= match[gi] ? '0 : since_next;
      end
    end

    // Saturating hit counter; clear beats a simultaneous match.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_reg <= '0;
      end else if (clr_cnt) begin
        cnt_reg <= '0;
      end else if (match[gi] && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign hit_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
  end

  // Registered match pulses so outputs never depend combinationally on inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      detect_reg <= '0;
      any_reg    <= 1'b0;
    end else begin
      detect_reg <= match;
      any_reg    <= |match;
    end
  end

  assign detect     = detect_reg;
  assign any_detect = any_reg;

endmodule

// File: tb/tb_multi_seq_detector.sv
// tb_multi_seq_detector: directed vectors with a scoreboard queue of expected
// detect vectors, popped by a monitor once per clock edge.
module tb_multi_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       x_valid;
  logic       x;
  logic       overlap;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_pat;
  logic [2:0] cfg_len;
  logic       clr_cnt;
  logic [2:0] detect;
  logic       any_detect;
  logic [5:0] hit_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];

  multi_seq_detector #(
    .NUM_PAT (3),
    .PAT_LEN (4),
    .CNT_W   (2),
    .DEF_PATS({4'b1111, 4'b1001, 4'b1011}),
    .DEF_LEN (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x_valid   (x_valid),
    .x         (x),
    .overlap   (overlap),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .clr_cnt   (clr_cnt),
    .detect    (detect),
    .any_detect(any_detect),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  // One clock edge of stimulus plus its expected detect vector.
  task automatic drive(input logic xv, input logic xb, input logic ov, input logic we,
                       input logic [1:0] idx, input logic [3:0] pat,
                       input logic [2:0] len, input logic clr, input logic [2:0] e);
    @(negedge clk);
    x_valid = xv; x = xb; overlap = ov; cfg_we = we;
    cfg_idx = idx; cfg_pat = pat; cfg_len = len; clr_cnt = clr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x_valid = 1'b0; cfg_we = 1'b0; clr_cnt = 1'b0;
    $display("edge: xv=%0b x=%0b ov=%0b we=%0b idx=%0d pat=%b len=%0d clr=%0b exp=%b",
             xv, xb, ov, we, idx, pat, len, clr, e);
  endtask

  task automatic send(input logic xb, input logic ov, input logic [2:0] e);
    drive(1'b1, xb, ov, 1'b0, 2'd0, 4'd0, 3'd0, 1'b0, e);
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [3:0] pat, input logic [2:0] len);
    drive(1'b0, 1'b0, 1'b1, 1'b1, idx, pat, len, 1'b0, 3'b000);
  endtask

  task automatic clr();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 3'd0, 1'b1, 3'b000);
  endtask

  // s: bits in arrival order; e: expected detect vector per bit as a digit.
  task automatic stream(input string s, input logic ov, input string e, input bit gaps);
    logic [7:0] d;
    for (int i = 0; i < s.len(); i++) begin
      d = e[i] - 8'd48;
      send(s[i] == "1", ov, d[2:0]);
      if (gaps) drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 3'd0, 1'b0, 3'b000);
    end
  endtask

  // Monitor: compare every edge's output against the scoreboard.
  always @(posedge clk) begin
    logic [2:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({any_detect, detect} === {|e, e}) n_pass++;
      else $display("FAIL detect: got any=%0b det=%b, expected any=%0b det=%b",
                    any_detect, detect, |e, e);
    end else if ({any_detect, detect} !== 4'b0000) begin
      n_checks++;
      $display("FAIL idle_detect: got any=%0b det=%b, expected 0", any_detect, detect);
    end
  end

  initial begin
    reset = 1'b0; x_valid = 1'b0; x = 1'b0; overlap = 1'b1; cfg_we = 1'b0;
    cfg_idx = '0; cfg_pat = '0; cfg_len = '0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_detect", {5'd0, detect}, 8'd0);
    chk("reset_any", {7'd0, any_detect}, 8'd0);
    chk("reset_cnt", {2'd0, hit_cnt}, 8'd0);
    @(negedge clk) reset = 1'b1;

    // Overlapping 1011 twice.
    stream("1011011", 1'b1, "0001001", 1'b0);
    chk("cnt_overlap", {2'd0, hit_cnt}, 8'h02);
    clr();
    chk("cnt_clear", {2'd0, hit_cnt}, 8'h00);

    // Non-overlapping: second occurrence suppressed.
    cfg(2'd0, 4'b1011, 3'd4);
    stream("1011011", 1'b0, "0001000", 1'b0);
    chk("cnt_nonoverlap", {2'd0, hit_cnt}, 8'h01);
    clr();

    // Both default patterns with idle gaps.
    cfg(2'd0, 4'b1011, 3'd4);
    stream("1001011", 1'b1, "0002001", 1'b1);
    chk("cnt_two_pats", {2'd0, hit_cnt}, 8'h05);

    // Short pattern "11" in slot 1.
    cfg(2'd1, 4'b0011, 3'd2);
    stream("11", 1'b1, "02", 1'b0);

    // "00" in slot 1: fill gate, overlap, then non-overlap spacing.
    cfg(2'd1, 4'b0000, 3'd2);
    send(1'b0, 1'b1, 3'b000);
    send(1'b0, 1'b1, 3'b010);
    send(1'b0, 1'b1, 3'b010);
    send(1'b0, 1'b0, 3'b000);
    send(1'b0, 1'b0, 3'b010);

    // Slot disabled by len 0; out-of-range write keeps history intact.
    cfg(2'd1, 4'b1001, 3'd0);
    stream("1001", 1'b1, "0000", 1'b0);
    stream("101", 1'b1, "000", 1'b0);
    cfg(2'd3, 4'b0000, 3'd1);
    stream("1", 1'b1, "1", 1'b0);

    // Saturation with clamped length write.
    clr();
    cfg(2'd0, 4'b1011, 3'd7);
    stream("1011011011011011", 1'b1, "0001001001001001", 1'b0);
    chk("cnt_saturate", {2'd0, hit_cnt}, 8'h03);
    stream("01", 1'b1, "00", 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 3'd0, 1'b1, 3'b001);
    chk("cnt_clr_wins", {2'd0, hit_cnt}, 8'h00);

    // Config write on a valid bit drops that bit.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b1011, 3'd4, 1'b0, 3'b000);
    stream("011", 1'b1, "000", 1'b0);

    // Async reset mid-pattern.
    stream("101101", 1'b1, "000100", 1'b0);
    chk("cnt_before_rst", {2'd0, hit_cnt}, 8'h01);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("midrst_cnt", {2'd0, hit_cnt}, 8'h00);
    chk("midrst_detect", {4'd0, any_detect, detect}, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stream("1", 1'b1, "0", 1'b0);
    stream("1011", 1'b1, "0001", 1'b0);
    stream("001", 1'b1, "002", 1'b0);
    chk("cnt_after_rst", {2'd0, hit_cnt}, 8'h05);

    repeat (4) @(posedge clk);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
